// File: rtl/z3_bus_frontend.sv
// -----------------------------------------------------------------------------
// z3_bus_frontend
//
// Zorro III bus front end feeding the autoconfig / RAM-decode stage.
// Brings the raw bus strobes into the CLK domain, captures the multiplexed
// address at the start of each bus cycle, decodes autoconfig-space and
// configured-RAM-space hits and tracks the cycle with start/end pulses and a
// stuck-cycle timeout flag.
//
// Parameters
//   CFG_BASE    A[31:24] of Zorro III autoconfig space
//   CFG_PAGE    A[23:16] of autoconfig space
//   TIMEOUT     CLK cycles a cycle may stay active before stuck asserts
//
// Ports
//   CLK, RESET_n       clock, asynchronous active-low reset
//   AD_ADDR[23:0]      raw A[31:8] from the multiplexed AD bus
//   A_LOW[5:0]         raw A[7:2]
//   FCS_n_raw          raw full-cycle strobe
//   DS_n_raw[3:0]      raw data strobes, lanes 3..0
//   READ_raw           raw read/write (1 = read)
//   FC_raw[2:0]        raw function codes
//   addr_match[3:0]    assigned RAM base A[31:28]
//   configured         autoconfig has completed
//   FCS_n, DS_n        synchronised strobes (DS_n low when any lane is low)
//   READ, FC, ADDRL    values captured at cycle start
//   cfg_hit, ram_hit   address decode results captured at cycle start
//   match              configured ? ram_hit : cfg_hit, captured at cycle start
//   cycle_start        one-CLK pulse on the edge FCS_n first reads low
//   cycle_end          one-CLK pulse when the cycle returns to idle
//   stuck              active cycle has lasted TIMEOUT CLKs
// -----------------------------------------------------------------------------
module z3_bus_frontend #(
  parameter logic [7:0]  CFG_BASE = 8'hFF,
  parameter logic [7:0]  CFG_PAGE = 8'h00,
  parameter logic [15:0] TIMEOUT  = 16'd4096
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [23:0] AD_ADDR,
  input  logic [5:0]  A_LOW,
  input  logic        FCS_n_raw,
  input  logic [3:0]  DS_n_raw,
  input  logic        READ_raw,
  input  logic [2:0]  FC_raw,
  input  logic [3:0]  addr_match,
  input  logic        configured,
  output logic        FCS_n,
  output logic        DS_n,
  output logic        READ,
  output logic [2:0]  FC,
  output logic [6:0]  ADDRL,
  output logic        cfg_hit,
  output logic        ram_hit,
  output logic        match,
  output logic        cycle_start,
  output logic        cycle_end,
  output logic        stuck
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  logic       fcs_s0_q;
  logic       fcs_s1_q;
  logic [3:0] ds_s0_q;
  logic [3:0] ds_s1_q;
  logic       read_s0_q;
  logic [2:0] fc_s0_q;

  // READ and FC only matter at cycle start: their second flop is the capture
  // register itself, loaded on the same edge that FCS s1 takes the value now
  // in FCS s0, so the captured READ/FC line up with the FCS sample.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      fcs_s0_q  <= 1'b1;
      fcs_s1_q  <= 1'b1;
      ds_s0_q   <= 4'hF;
      ds_s1_q   <= 4'hF;
      read_s0_q <= 1'b0;
      fc_s0_q   <= 3'b000;
    end else begin
      fcs_s0_q  <= FCS_n_raw;
      fcs_s1_q  <= fcs_s0_q;
      ds_s0_q   <= DS_n_raw;
      ds_s1_q   <= ds_s0_q;
      read_s0_q <= READ_raw;
      fc_s0_q   <= FC_raw;
    end
  end

  logic ds_any_n;
  assign ds_any_n = &ds_s1_q;

  // ---------------------------------------------------------------------------
  // Address capture
  // ---------------------------------------------------------------------------
  // Layout: {A[31:8], A[7:2]}. The register follows the bus while FCS s0 is
  // high, so its last load is the edge on which FCS_n_raw is first sampled
  // low; from then on it is frozen until FCS s0 reads high again. It carries
  // no reset so that it keeps tracking the bus during reset, which gives a
  // cycle already in progress at reset release a valid address.
  logic [29:0] addr_q;

  always_ff @(posedge CLK) begin
    if (fcs_s0_q) begin
      addr_q <= {AD_ADDR, A_LOW};
    end
  end

  // A[15:9] are not part of any decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[13:7];

  logic cfg_hit_d;
  logic ram_hit_d;
  assign cfg_hit_d = (addr_q[29:22] == CFG_BASE) && (addr_q[21:14] == CFG_PAGE);
  assign ram_hit_d = (addr_q[29:26] == addr_match);

  // ---------------------------------------------------------------------------
  // Cycle tracker FSM
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   start_d;
  logic   end_d;

  // Entry looks at FCS s0 (the value FCS s1 takes on this edge) so that
  // cycle_start and the decode land on the same edge FCS_n first reads low.
  // Exits look at the registered FCS s1, which gives cycle_end one CLK after
  // FCS_n has gone high. FCS is tested before DS so a simultaneous DS fall
  // and FCS rise ends the cycle.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fcs_s0_q) begin
          state_d = ST_ADDR;
          start_d = 1'b1;
        end
      end
      ST_ADDR: begin
        if (fcs_s1_q) begin
          state_d = ST_IDLE;
        end else if (!ds_any_n) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fcs_s1_q) begin
          state_d = ST_IDLE;
        end else if (ds_any_n) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (fcs_s1_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
      end_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout counter
  // ---------------------------------------------------------------------------
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        stuck_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = 16'd0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
    // Leaving for IDLE clears stuck on the same edge.
    stuck_d = (state_d != ST_IDLE) && (cnt_d >= TIMEOUT);
  end

  // ---------------------------------------------------------------------------
  // State, pulses and captured cycle attributes
  // ---------------------------------------------------------------------------
  logic       read_q;
  logic [2:0] fc_q;
  logic [6:0] addrl_q;
  logic       cfg_hit_q;
  logic       ram_hit_q;
  logic       match_q;
  logic       start_q;
  logic       end_q;
  logic       stuck_q;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      stuck_q   <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      read_q    <= 1'b0;
      fc_q      <= 3'b000;
      addrl_q   <= 7'd0;
      cfg_hit_q <= 1'b0;
      ram_hit_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stuck_q <= stuck_d;
      start_q <= start_d;
      end_q   <= end_d;
      // Captured attributes persist until the next cycle start; addr_match
      // and configured are sampled here so later base writes do not disturb
      // the cycle in flight.
      if (start_d) begin
        read_q    <= read_s0_q;
        fc_q      <= fc_s0_q;
        addrl_q   <= addr_q[6:0];
        cfg_hit_q <= cfg_hit_d;
        ram_hit_q <= ram_hit_d;
        match_q   <= configured ? ram_hit_d : cfg_hit_d;
      end
    end
  end

  assign FCS_n       = fcs_s1_q;
  assign DS_n        = ds_any_n;
  assign READ        = read_q;
  assign FC          = fc_q;
  assign ADDRL       = addrl_q;
  assign cfg_hit     = cfg_hit_q;
  assign ram_hit     = ram_hit_q;
  assign match       = match_q;
  assign cycle_start = start_q;
  assign cycle_end   = end_q;
  assign stuck       = stuck_q;

endmodule

// File: tb/tb_z3_bus_frontend.sv
// -----------------------------------------------------------------------------
// tb_z3_bus_frontend
//
// Self-checking bench for z3_bus_frontend. Raw bus inputs are driven on the
// falling CLK edge and outputs are sampled on the falling edge after each
// rising edge. Expected values come from the bus timing rules written in
// terms of "edges since FCS_n_raw was first sampled low" plus a decode
// function working directly on the 24-bit bus address.
// -----------------------------------------------------------------------------
module tb_z3_bus_frontend;

  localparam logic [7:0] CB = 8'hFF;
  localparam logic [7:0] CP = 8'h00;
  localparam int         TO = 16;

  // {FCS_n, DS_n, cycle_start, cycle_end, stuck, READ, FC, ADDRL, cfg, ram, match}
  localparam logic [18:0] RST_V = {2'b11, 17'd0};

  logic        CLK;
  logic        RESET_n;
  logic [23:0] AD_ADDR;
  logic [5:0]  A_LOW;
  logic        FCS_n_raw;
  logic [3:0]  DS_n_raw;
  logic        READ_raw;
  logic [2:0]  FC_raw;
  logic [3:0]  addr_match;
  logic        configured;
  logic        FCS_n;
  logic        DS_n;
  logic        READ;
  logic [2:0]  FC;
  logic [6:0]  ADDRL;
  logic        cfg_hit;
  logic        ram_hit;
  logic        match;
  logic        cycle_start;
  logic        cycle_end;
  logic        stuck;

  int errors = 0;
  int checks = 0;

  // Decode fields of the most recently started cycle.
  logic [13:0] last_dec;

  z3_bus_frontend #(
    .CFG_BASE(CB),
    .CFG_PAGE(CP),
    .TIMEOUT (16'(TO))
  ) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .AD_ADDR    (AD_ADDR),
    .A_LOW      (A_LOW),
    .FCS_n_raw  (FCS_n_raw),
    .DS_n_raw   (DS_n_raw),
    .READ_raw   (READ_raw),
    .FC_raw     (FC_raw),
    .addr_match (addr_match),
    .configured (configured),
    .FCS_n      (FCS_n),
    .DS_n       (DS_n),
    .READ       (READ),
    .FC         (FC),
    .ADDRL      (ADDRL),
    .cfg_hit    (cfg_hit),
    .ram_hit    (ram_hit),
    .match      (match),
    .cycle_start(cycle_start),
    .cycle_end  (cycle_end),
    .stuck      (stuck)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Reference model and helpers
  // ---------------------------------------------------------------------------
  // {READ, FC, ADDRL, cfg_hit, ram_hit, match} for a cycle on bus address a.
  function automatic logic [13:0] exp_dec(input logic [23:0] a, input logic [5:0] al,
                                          input logic rd, input logic [2:0] fc,
                                          input logic cfgd, input logic [3:0] am);
    logic c;
    logic r;
    c = (a[23:16] == CB) && (a[15:8] == CP);
    r = (a[23:20] == am);
    return {rd, fc, a[0], al, c, r, (cfgd ? r : c)};
  endfunction

  function automatic logic [18:0] obs();
    return {FCS_n, DS_n, cycle_start, cycle_end, stuck, READ, FC, ADDRL, cfg_hit, ram_hit, match};
  endfunction

  function automatic logic [13:0] obs_dec();
    return {READ, FC, ADDRL, cfg_hit, ram_hit, match};
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    FCS_n_raw = 1'b1;
    DS_n_raw  = 4'hF;
    repeat (n) tick();
  endtask

  task automatic drive_start(input logic [23:0] a, input logic [5:0] al, input logic rd,
                             input logic [2:0] fc, input logic cfgd, input logic [3:0] am);
    AD_ADDR    = a;
    A_LOW      = al;
    READ_raw   = rd;
    FC_raw     = fc;
    configured = cfgd;
    addr_match = am;
    FCS_n_raw  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RESET_n    = 1'b0;
    FCS_n_raw  = 1'b1;
    DS_n_raw   = 4'hF;
    READ_raw   = 1'b1;
    FC_raw     = 3'b111;
    AD_ADDR    = 24'hFF0001;
    A_LOW      = 6'h3F;
    addr_match = 4'hF;
    configured = 1'b1;
    repeat (2) tick();
    checks++;
    if (obs() !== RST_V) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs(), RST_V);
    end
    FCS_n_raw = 1'b0;
    DS_n_raw  = 4'h0;
    repeat (3) tick();
    checks++;
    if (obs() !== RST_V) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", obs(), RST_V);
    end
    FCS_n_raw = 1'b1;
    DS_n_raw  = 4'hF;
    repeat (2) tick();
    RESET_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== RST_V) begin
        errors++;
        $display("FAIL reset_release edge %0d: got %h expected %h", i, obs(), RST_V);
      end
    end
    last_dec = '0;
  endtask

  task automatic test_cfg_read();
    int          L = 8;
    int          D = 3;
    int          N = 3;
    logic [13:0] dec;
    logic [18:0] exp_v;
    dec = exp_dec(24'hFF0001, 6'h01, 1'b1, 3'b101, 1'b0, 4'h0);
    drive_start(24'hFF0001, 6'h01, 1'b1, 3'b101, 1'b0, 4'h0);
    for (int i = 0; i <= L + 3; i++) begin
      FCS_n_raw = (i < L) ? 1'b0 : 1'b1;
      DS_n_raw  = (i >= D && i < D + N) ? 4'b1100 : 4'hF;
      tick();
      exp_v = {!(i >= 1 && i <= L), !(i >= D + 1 && i <= D + N), (i == 1), (i == L + 2),
               1'b0, ((i >= 1) ? dec : last_dec)};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL cfg_read edge %0d: got %h expected %h", i, obs(), exp_v);
      end
    end
    checks++;
    if (ADDRL !== 7'h41) begin
      errors++;
      $display("FAIL cfg_read_addrl: got %h expected %h", ADDRL, 7'h41);
    end
    last_dec = dec;
    idle(2);
  endtask

  task automatic test_ram_hit();
    logic [23:0] a;
    logic [5:0]  al;
    logic [3:0]  am;
    logic [13:0] dec;
    for (int r = 0; r < 2; r++) begin
      am  = (r == 0) ? 4'h4 : 4'h5;
      a   = {4'h4, 20'($urandom)};
      al  = 6'($urandom);
      dec = exp_dec(a, al, 1'b0, 3'b010, 1'b1, am);
      drive_start(a, al, 1'b0, 3'b010, 1'b1, am);
      for (int i = 0; i <= 7; i++) begin
        FCS_n_raw = (i < 4) ? 1'b0 : 1'b1;
        tick();
        if (i == 1) begin
          checks++;
          if (obs_dec() !== dec) begin
            errors++;
            $display("FAIL ram_hit_decode am=%h: got %h expected %h", am, obs_dec(), dec);
          end
          checks++;
          if (match !== (r == 0) || ram_hit !== (r == 0)) begin
            errors++;
            $display("FAIL ram_hit_match am=%h: got match=%b ram_hit=%b expected %b",
                     am, match, ram_hit, (r == 0));
          end
        end
      end
      last_dec = dec;
      idle(2);
    end
  endtask

  task automatic test_abort();
    int L = 3;
    int n_end = 0;
    int n_start = 0;
    int end_at = -1;
    int stuck_seen = 0;
    drive_start(24'h123456, 6'h15, 1'b1, 3'b001, 1'b0, 4'h1);
    for (int i = 0; i <= L + 5; i++) begin
      FCS_n_raw = (i < L) ? 1'b0 : 1'b1;
      DS_n_raw  = 4'hF;
      tick();
      if (cycle_end === 1'b1) begin
        n_end++;
        end_at = i;
      end
      if (cycle_start === 1'b1) n_start++;
      if (stuck !== 1'b0) stuck_seen++;
    end
    checks++;
    if (n_end != 1 || end_at != L + 2) begin
      errors++;
      $display("FAIL abort_end: got %0d pulses at edge %0d expected 1 at edge %0d",
               n_end, end_at, L + 2);
    end
    checks++;
    if (n_start != 1) begin
      errors++;
      $display("FAIL abort_start: got %0d pulses expected 1", n_start);
    end
    checks++;
    if (stuck_seen != 0) begin
      errors++;
      $display("FAIL abort_stuck: got %0d stuck edges expected 0", stuck_seen);
    end
    last_dec = exp_dec(24'h123456, 6'h15, 1'b1, 3'b001, 1'b0, 4'h1);
    idle(2);
  endtask

  task automatic test_addr_change();
    drive_start(24'hFF0000, 6'h2A, 1'b1, 3'b011, 1'b0, 4'h0);
    for (int i = 0; i <= 8; i++) begin
      FCS_n_raw = (i < 5) ? 1'b0 : 1'b1;
      if (i == 1) begin
        AD_ADDR = 24'h000000;
        A_LOW   = 6'h00;
      end
      tick();
      if (i >= 1 && i <= 3) begin
        checks++;
        if (ADDRL !== 7'h2A || cfg_hit !== 1'b1 || match !== 1'b1) begin
          errors++;
          $display("FAIL addr_change edge %0d: got ADDRL=%h cfg_hit=%b match=%b expected 2a 1 1",
                   i, ADDRL, cfg_hit, match);
        end
      end
    end
    last_dec = exp_dec(24'hFF0000, 6'h2A, 1'b1, 3'b011, 1'b0, 4'h0);
    idle(2);
  endtask

  task automatic test_timeout();
    int   L = 40;
    logic exp_s;
    drive_start(24'h89ABCD, 6'h07, 1'b0, 3'b110, 1'b1, 4'h8);
    for (int i = 0; i <= L + 3; i++) begin
      FCS_n_raw = (i < L) ? 1'b0 : 1'b1;
      DS_n_raw  = (i >= 2 && i < 4) ? 4'b0000 : 4'hF;
      tick();
      exp_s = (i >= TO + 1) && (i <= L + 1);
      checks++;
      if (stuck !== exp_s || cycle_end !== (i == L + 2)) begin
        errors++;
        $display("FAIL timeout edge %0d: got stuck=%b end=%b expected stuck=%b end=%b",
                 i, stuck, cycle_end, exp_s, (i == L + 2));
      end
    end
    last_dec = exp_dec(24'h89ABCD, 6'h07, 1'b0, 3'b110, 1'b1, 4'h8);
    idle(2);
  endtask

  task automatic test_back_to_back();
    int          L1 = 4;
    int          L2 = 4;
    logic [13:0] dec_a;
    logic [13:0] dec_b;
    logic        exp_st;
    logic        exp_en;
    dec_a = exp_dec(24'hFF00FE, 6'h11, 1'b1, 3'b100, 1'b0, 4'h3);
    dec_b = exp_dec(24'h3C0001, 6'h22, 1'b0, 3'b011, 1'b1, 4'h3);
    drive_start(24'hFF00FE, 6'h11, 1'b1, 3'b100, 1'b0, 4'h3);
    for (int i = 0; i <= L1 + 1 + L2 + 3; i++) begin
      if (i == L1 + 1) drive_start(24'h3C0001, 6'h22, 1'b0, 3'b011, 1'b1, 4'h3);
      FCS_n_raw = (i < L1 || (i >= L1 + 1 && i < L1 + 1 + L2)) ? 1'b0 : 1'b1;
      DS_n_raw  = ((i >= 1 && i < 3) || (i >= L1 + 2 && i < L1 + 4)) ? 4'b0111 : 4'hF;
      tick();
      exp_st = (i == 1) || (i == L1 + 3);
      exp_en = (i == L1 + 2) || (i == L1 + 1 + L2 + 2);
      checks++;
      if (cycle_start !== exp_st || cycle_end !== exp_en) begin
        errors++;
        $display("FAIL b2b_pulses edge %0d: got start=%b end=%b expected start=%b end=%b",
                 i, cycle_start, cycle_end, exp_st, exp_en);
      end
      if (i == L1 + 2) begin
        checks++;
        if (obs_dec() !== dec_a) begin
          errors++;
          $display("FAIL b2b_hold_a: got %h expected %h", obs_dec(), dec_a);
        end
      end
      if (i == L1 + 3) begin
        checks++;
        if (obs_dec() !== dec_b) begin
          errors++;
          $display("FAIL b2b_decode_b: got %h expected %h", obs_dec(), dec_b);
        end
      end
    end
    last_dec = dec_b;
    idle(2);
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [5:0]  al;
    logic        rd;
    logic [2:0]  fc;
    logic        cfgd;
    logic [3:0]  am;
    logic [3:0]  lanes;
    logic [13:0] dec;
    logic [18:0] exp_v;
    int          L;
    int          D;
    int          N;
    bit          use_ds;
    for (int n = 0; n < 25; n++) begin
      am   = 4'($urandom);
      cfgd = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       a = {CB, CP, 8'($urandom)};
        1:       a = {am, 20'($urandom)};
        default: a = 24'($urandom);
      endcase
      al     = 6'($urandom);
      rd     = 1'($urandom);
      fc     = 3'($urandom);
      L      = $urandom_range(2, 12);
      D      = $urandom_range(0, L - 1);
      N      = $urandom_range(1, L - D);
      use_ds = ($urandom_range(0, 3) != 0);
      lanes  = 4'($urandom_range(0, 14));
      dec    = exp_dec(a, al, rd, fc, cfgd, am);
      drive_start(a, al, rd, fc, cfgd, am);
      for (int i = 0; i <= L + 3; i++) begin
        if (i == 1) begin
          AD_ADDR = 24'($urandom);
          A_LOW   = 6'($urandom);
        end
        FCS_n_raw = (i < L) ? 1'b0 : 1'b1;
        DS_n_raw  = (use_ds && i >= D && i < D + N) ? lanes : 4'hF;
        tick();
        exp_v = {!(i >= 1 && i <= L), !(use_ds && i >= D + 1 && i <= D + N), (i == 1),
                 (i == L + 2), ((i >= TO + 1) && (i <= L + 1)),
                 ((i >= 1) ? dec : last_dec)};
        checks++;
        if (obs() !== exp_v) begin
          errors++;
          $display("FAIL random cycle %0d edge %0d: got %h expected %h", n, i, obs(), exp_v);
        end
      end
      last_dec = dec;
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic [23:0] a;
    logic [3:0]  am;
    logic [13:0] dec;
    logic [18:0] exp_v;
    drive_start(24'hFF0003, 6'h0C, 1'b1, 3'b111, 1'b0, 4'h2);
    for (int i = 0; i <= 4; i++) begin
      FCS_n_raw = 1'b0;
      DS_n_raw  = (i >= 1) ? 4'b1010 : 4'hF;
      tick();
    end
    #2;
    RESET_n = 1'b0;
    #1;
    checks++;
    if (obs() !== RST_V) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected %h", obs(), RST_V);
    end
    FCS_n_raw = 1'b1;
    DS_n_raw  = 4'hF;
    repeat (2) tick();
    RESET_n  = 1'b1;
    last_dec = '0;
    idle(3);
    am  = 4'($urandom);
    a   = {am, 20'($urandom)};
    dec = exp_dec(a, 6'h33, 1'b1, 3'b001, 1'b1, am);
    drive_start(a, 6'h33, 1'b1, 3'b001, 1'b1, am);
    for (int i = 0; i <= 7; i++) begin
      FCS_n_raw = (i < 4) ? 1'b0 : 1'b1;
      tick();
      exp_v = {!(i >= 1 && i <= 4), 1'b1, (i == 1), (i == 6), 1'b0,
               ((i >= 1) ? dec : last_dec)};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_next edge %0d: got %h expected %h", i, obs(), exp_v);
      end
    end
    last_dec = dec;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_cfg_read();
    test_ram_hit();
    test_abort();
    test_addr_change();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
